alu_pipe_acc: RTL
=================

// Module: alu_pipe_acc
// PURPOSE
//   Parametrised registered ALU; next generation of the combinational 4-bit AND datapath.
//   Adds eight ops, status flags, an accumulator operand mode and a valid/ready handshake.
//   Sits between the operand/instruction source and the result sink in the ALU datapath.
// PARAMETERS
//   WIDTH     8      operand/result width in bits (>=2)
//   ACC_INIT  0      accumulator value loaded at reset and by op CLRACC
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operand/op presented
//   in_ready   out  1      block can accept this cycle
//   op         in   3      000 AND, 001 OR, 010 XOR, 011 NOTA, 100 ADD, 101 SUB, 110 SHL, 111 CLRACC
//   use_acc    in   1      1: operand A = accumulator, a ignored
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B (SHL: shift amount = b[$clog2(WIDTH)-1:0])
//   out_valid  out  1      result/flags valid
//   out_ready  in   1      sink accepts result
//   result     out  WIDTH  registered result
//   flag_z     out  1      result == 0
//   flag_n     out  1      result[WIDTH-1]
//   flag_c     out  1      ADD carry-out; SUB borrow (A<B unsigned); SHL last bit shifted out; else 0
//   flag_v     out  1      signed overflow for ADD/SUB; else 0
//   acc        out  WIDTH  current accumulator value
// BEHAVIOUR
//   - Reset (rst=1 at clk edge): out_valid=0, result=0, all flags=0, acc=ACC_INIT. rst overrides all.
//   - in_ready = !out_valid || out_ready (combinational; single output stage, no skid).
//   - Accept: in_valid && in_ready at clk edge. Latency 1: result/flags registered that edge,
//     out_valid=1 next cycle. Full throughput (1 op/cycle) while out_ready=1.
//   - Hold: out_valid && !out_ready -> result, flags, out_valid stable; in_ready=0, input ignored.
//   - Drain: out_valid && out_ready && !accept -> out_valid=0 next cycle; result keeps value.
//   - Simultaneous drain+accept: new result replaces old same edge, out_valid stays 1.
//   - Arithmetic: all ops modulo 2^WIDTH. SUB = A + ~B + 1; flag_c = 1 on borrow.
//     flag_v(ADD) = (A[msb]==B[msb]) && (R[msb]!=A[msb]);
//     flag_v(SUB) = (A[msb]!=B[msb]) && (R[msb]!=A[msb]).
//     SHL by 0 -> R=A, flag_c=0. NOTA -> R=~A.
//   - Accumulator: on every accepted op, acc <= result (write-back). CLRACC: result=ACC_INIT,
//     acc<=ACC_INIT, flags computed from ACC_INIT (c=v=0). Back-to-back use_acc ops see the
//     value written by the previous accepted op (internal bypass, no bubble).
//   - acc unchanged by non-accepted cycles (stall, in_valid=0).
//   - Reset mid-stall: pending result discarded, out_valid=0 next cycle, acc=ACC_INIT.
// TESTING
//   1 WIDTH=4: a=1100,b=1010,AND -> next cycle result=1000, out_valid=1, z=0, n=1.
//   2 WIDTH=8 ADD a=0x7F,b=0x01 -> result=0x80, v=1, n=1, c=0; ADD 0xFF+0x01 -> 0x00, z=1, c=1, v=0.
//   3 SUB a=0x05,b=0x07 -> result=0xFE, c=1, n=1; SHL a=0x81,b=1 -> 0x02, c=1.
//   4 use_acc chain: CLRACC, then ADD b=3 x4 back-to-back (out_ready=1) -> results 3,6,9,12; acc=12.
//   5 out_ready=0 for 3 cycles after one accept -> in_ready=0, result stable, 2nd op accepted only
//     on the cycle out_ready returns 1; no op lost or duplicated (scoreboard vs model).
//   6 rst=1 during stall with acc=0x12 -> next cycle out_valid=0, result=0, acc=ACC_INIT.

Source files
------------

// File: rtl/alu_pipe_acc_if.sv
// Operand/op request and result/flag response channel of the pipelined ALU.
interface alu_pipe_acc_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic             use_acc;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;
  logic [WIDTH-1:0] acc;

  // Source/sink side: presents operands, consumes results
  modport master (
    output in_valid, op, use_acc, a, b, out_ready,
    input  in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v, acc
  );

  // ALU side
  modport slave (
    input  in_valid, op, use_acc, a, b, out_ready,
    output in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v, acc
  );
endinterface

// File: rtl/alu_pipe_acc.sv
// Registered ALU with flags, accumulator operand mode and a single valid/ready output stage.
module alu_pipe_acc #(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic           clk,
  input  logic           rst,
  alu_pipe_acc_if.slave  bus
);

  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_AND    = 3'b000;
  localparam logic [2:0] OP_OR     = 3'b001;
  localparam logic [2:0] OP_XOR    = 3'b010;
  localparam logic [2:0] OP_NOTA   = 3'b011;
  localparam logic [2:0] OP_ADD    = 3'b100;
  localparam logic [2:0] OP_SUB    = 3'b101;
  localparam logic [2:0] OP_SHL    = 3'b110;
  localparam logic [2:0] OP_CLRACC = 3'b111;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q,    result_d;
  logic             flag_z_q,    flag_z_d;
  logic             flag_n_q,    flag_n_d;
  logic             flag_c_q,    flag_c_d;
  logic             flag_v_q,    flag_v_d;
  logic [WIDTH-1:0] acc_q,       acc_d;

  logic             in_ready_c;
  logic             accept_c;
  logic [WIDTH-1:0] opa_c;
  logic [WIDTH-1:0] opb_c;
  logic [WIDTH:0]   sum_ext_c;
  logic [WIDTH:0]   diff_ext_c;
  logic [WIDTH:0]   shl_ext_c;
  logic [WIDTH-1:0] alu_r_c;
  logic             alu_c_c;
  logic             alu_v_c;

  // Single output stage: room whenever it is empty or being drained this cycle
  assign in_ready_c = !out_valid_q || bus.out_ready;
  assign accept_c   = bus.in_valid && in_ready_c;

  // acc_q already holds the previous accepted result, so back-to-back use_acc needs no bubble
  assign opa_c = bus.use_acc ? acc_q : bus.a;
  assign opb_c = bus.b;

  // Combinational datapath: result, carry/borrow and signed overflow
  always_comb begin
    sum_ext_c  = {1'b0, opa_c} + {1'b0, opb_c};
    diff_ext_c = {1'b0, opa_c} - {1'b0, opb_c};
    shl_ext_c  = {1'b0, opa_c} << opb_c[SHW-1:0];
    alu_r_c    = '0;
    alu_c_c    = 1'b0;
    alu_v_c    = 1'b0;
    case (bus.op)
      OP_AND:  alu_r_c = opa_c & opb_c;
      OP_OR:   alu_r_c = opa_c | opb_c;
      OP_XOR:  alu_r_c = opa_c ^ opb_c;
      OP_NOTA: alu_r_c = ~opa_c;
      OP_ADD: begin
        alu_r_c = sum_ext_c[WIDTH-1:0];
        alu_c_c = sum_ext_c[WIDTH];
        alu_v_c = (opa_c[WIDTH-1] == opb_c[WIDTH-1]) &&
                  (sum_ext_c[WIDTH-1] != opa_c[WIDTH-1]);
      end
      OP_SUB: begin
        // Borrow shows up as the extension bit of the unsigned difference
        alu_r_c = diff_ext_c[WIDTH-1:0];
        alu_c_c = diff_ext_c[WIDTH];
        alu_v_c = (opa_c[WIDTH-1] != opb_c[WIDTH-1]) &&
                  (diff_ext_c[WIDTH-1] != opa_c[WIDTH-1]);
      end
      OP_SHL: begin
        // Extension bit catches the last bit shifted out; zero for a shift of 0
        alu_r_c = shl_ext_c[WIDTH-1:0];
        alu_c_c = shl_ext_c[WIDTH];
      end
      OP_CLRACC: alu_r_c = ACC_INIT;
      default:   alu_r_c = '0;
    endcase
  end

  // Next-state for the output stage and accumulator
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flag_z_d    = flag_z_q;
    flag_n_d    = flag_n_q;
    flag_c_d    = flag_c_q;
    flag_v_d    = flag_v_q;
    acc_d       = acc_q;
    if (accept_c) begin
      out_valid_d = 1'b1;
      result_d    = alu_r_c;
      flag_z_d    = (alu_r_c == '0);
      flag_n_d    = alu_r_c[WIDTH-1];
      flag_c_d    = alu_c_c;
      flag_v_d    = alu_v_c;
      acc_d       = alu_r_c;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flag_z_q    <= 1'b0;
      flag_n_q    <= 1'b0;
      flag_c_q    <= 1'b0;
      flag_v_q    <= 1'b0;
      acc_q       <= ACC_INIT;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flag_z_q    <= flag_z_d;
      flag_n_q    <= flag_n_d;
      flag_c_q    <= flag_c_d;
      flag_v_q    <= flag_v_d;
      acc_q       <= acc_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flag_z    = flag_z_q;
  assign bus.flag_n    = flag_n_q;
  assign bus.flag_c    = flag_c_q;
  assign bus.flag_v    = flag_v_q;
  assign bus.acc       = acc_q;

endmodule
